instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped, read-only instruction cache between the pipelined CPU's instruction-memory port and the slower instruction memory. Hits are returned in the same cycle. A miss stalls the fetch stage while a 4-word line is fetched from memory and installed. The block also keeps hit and miss counters for performance reporting next to `num_inst`.

## Interface
Parameters:
- `LINES`, default 8: number of cache lines. Power of two, at least 2.
- `WORD_SIZE`, default 16: data and address width. Matches the global `WORD_SIZE` define.

Ports:
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `i_readM`  in  1  CPU fetch request.
- `i_address`  in  16  CPU fetch word address.
- `i_data`  out  16  fetched instruction; valid when `i_hit`=1, otherwise 16'h0000.
- `i_hit`  out  1  combinational: request hits this cycle.
- `i_stall`  out  1  combinational: `i_readM & ~i_hit`.
- `flush`  in  1  invalidate all lines (one-cycle pulse).
- `mem_readM`  out  1  line-fetch request to memory.
- `mem_address`  out  16  line-aligned word address; bits [1:0] are always 0.
- `mem_data`  in  64  fetched line; word k in bits [16k+15:16k].
- `mem_ready`  in  1  `mem_data` is valid this cycle.
- `num_hit`  out  16  hit counter.
- `num_miss`  out  16  miss counter.

## Operation
- Address split:
  - offset = `i_address`[1:0]
  - index = `i_address`[IB+1:2], where IB = log2(LINES)
  - tag = `i_address`[15:IB+2]
  - With LINES=8: index [4:2], tag [15:5] (11 bits).
- Per-line storage: valid bit, tag, 4 data words.
- `i_hit` = `i_readM` & state==IDLE & valid[index] & tag match. A hit is never reported outside IDLE.
- FSM states: IDLE, REQ.
- IDLE:
  - If `i_readM` & ~hit: latch `i_address` with [1:0] cleared into `mem_address`, increment `num_miss`, go to REQ.
  - If `flush` (or a pending flush) is set in IDLE, clear all valid bits at the edge. That cycle's lookup still uses the pre-flush valid bits.
  - `flush` and a miss in the same IDLE cycle: both take effect; the miss proceeds to REQ.
- REQ:
  - `mem_readM`=1.
  - On an edge with `mem_ready`=1: write `mem_data` into line index(`mem_address`), set its tag and valid, go to IDLE.
  - The line fill uses the latched address only; changes on `i_address` during REQ are ignored.
- `flush` during REQ sets `flush_pending`. At fill completion the line is still written but not marked valid, all valid bits are cleared, and `flush_pending` is cleared.
- Counters:
  - `num_hit` increments on each edge where `i_hit`=1.
  - `num_miss` increments on each IDLE→REQ transition.
  - Both wrap modulo 2^16.
- Replacement: a fill overwrites the indexed line unconditionally. Direct mapped, so there is no policy state.

## Timing
- Reset edge sets: state IDLE, all valid bits 0, `flush_pending` 0, `mem_readM` 0, `mem_address` 0, `num_hit` 0, `num_miss` 0.
- Before the first edge with reset deasserted, all outputs read as: `i_hit` 0, `i_data` 0, `i_stall` = `i_readM`.
- Reset asserted mid-REQ abandons the fill. `mem_readM` is low in the cycle after the reset edge, and no line is written.
- Hit latency: 0 cycles (combinational from `i_address`).
- Miss timing:
  - Miss detected in cycle C; REQ begins at C+1.
  - If `mem_ready` is first high in cycle C+k (k≥1), the line is installed at the end of C+k.
  - IDLE in C+k+1; the same address hits there.
  - Minimum miss penalty: 2 stall cycles.
- `mem_readM` and `mem_address` are registered (decoded from state) and held stable for the whole REQ.
- `mem_ready` is ignored outside REQ.

## Test plan
- Cold miss, then hit:
  - Stimulus: after reset, `i_readM`=1, `i_address`=16'h0012; memory returns 64'h0004_0003_0002_0001 with `mem_ready` in the first REQ cycle.
  - Required: `i_stall`=1 for 2 cycles; `mem_address`=16'h0010; then `i_hit`=1 with `i_data`=16'h0003; `num_miss`=1, `num_hit`=1.
- Spatial hits:
  - Stimulus: after the above, fetch 16'h0010, 16'h0011, 16'h0013.
  - Required: three consecutive hits returning 0001, 0002, 0004; `num_hit`=4; `mem_readM` stays 0.
- Conflict eviction (LINES=8):
  - Stimulus: fetch 16'h0030 (same index 4, different tag), then 16'h0010.
  - Required: both miss; `num_miss`=3; the second fetch re-requests `mem_address` 16'h0010.
- Slow memory with address change during REQ:
  - Stimulus: `mem_ready` delayed 5 cycles; `i_address` changes during REQ.
  - Required: `mem_address` held at the latched value; exactly one line installed.
- Flush during REQ:
  - Stimulus: pulse `flush` in the 2nd REQ cycle.
  - Required: after completion, all lines invalid; the original address misses again.
- Reset mid-REQ:
  - Stimulus: assert `Reset` in REQ.
  - Required: next cycle `mem_readM`=0, counters 0, the address misses.

Source files
------------

// File: rtl/instr_cache_if.sv
// instr_cache_if
// Groups the CPU fetch port, the line-fill memory port and the performance
// counters of the instruction cache into one bundle.
//   CPU side    : i_readM, i_address (to cache); i_data, i_hit, i_stall (from cache)
//   control     : flush (to cache)
//   memory side : mem_readM, mem_address (from cache); mem_data, mem_ready (to cache)
//   counters    : num_hit, num_miss (from cache)
// modport slave  - the cache itself
// modport master - the environment (CPU + memory) driving the cache
interface instr_cache_if #(
  parameter int WORD_SIZE = 16
);
  logic                     i_readM;
  logic [WORD_SIZE-1:0]     i_address;
  logic [WORD_SIZE-1:0]     i_data;
  logic                     i_hit;
  logic                     i_stall;
  logic                     flush;
  logic                     mem_readM;
  logic [WORD_SIZE-1:0]     mem_address;
  logic [4*WORD_SIZE-1:0]   mem_data;
  logic                     mem_ready;
  logic [WORD_SIZE-1:0]     num_hit;
  logic [WORD_SIZE-1:0]     num_miss;

  modport slave (
    input  i_readM, i_address, flush, mem_data, mem_ready,
    output i_data, i_hit, i_stall, mem_readM, mem_address, num_hit, num_miss
  );

  modport master (
    output i_readM, i_address, flush, mem_data, mem_ready,
    input  i_data, i_hit, i_stall, mem_readM, mem_address, num_hit, num_miss
  );
endinterface

// File: rtl/instr_cache.sv
// instr_cache
// Direct-mapped, read-only instruction cache with 4-word lines.
// Hits return data combinationally in the same cycle; a miss stalls the
// fetch stage while the line is fetched from instruction memory.
// Ports:
//   Clk   - single clock, all state changes on the rising edge
//   Reset - synchronous, active-high
//   bus   - instr_cache_if.slave: CPU fetch port, flush, memory fill port,
//           hit/miss performance counters
// Address split (word address): [1:0] offset, [IB+1:2] index, [top:IB+2] tag.
module instr_cache #(
  parameter int LINES     = 8,
  parameter int WORD_SIZE = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  instr_cache_if.slave  bus
);

  localparam int IB = $clog2(LINES);
  localparam int TW = WORD_SIZE - IB - 2;
  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Per-line storage
  logic [LINES-1:0]       r_valid;
  logic [TW-1:0]          r_tag  [LINES];
  logic [4*WORD_SIZE-1:0] r_line [LINES];

  // Flush requested while a fill was in flight; applied when the fill ends
  logic                   r_flush_pending;
  logic [WORD_SIZE-1:0]   r_mem_address;
  logic [WORD_SIZE-1:0]   r_num_hit;
  logic [WORD_SIZE-1:0]   r_num_miss;

  // Lookup path
  logic [1:0]             w_offset;
  logic [IB-1:0]          w_index;
  logic [TW-1:0]          w_tag;
  logic [4*WORD_SIZE-1:0] w_sel_line;
  logic [WORD_SIZE-1:0]   w_words [4];
  logic                   w_line_match;

  // Fill path uses the latched address only
  logic [IB-1:0]          w_fill_index;
  logic [TW-1:0]          w_fill_tag;

  // FSM decode
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_fill;
  logic                   w_flush_any;

  assign w_offset     = bus.i_address[1:0];
  assign w_index      = bus.i_address[IB+1:2];
  assign w_tag        = bus.i_address[WORD_SIZE-1:IB+2];
  assign w_sel_line   = r_line[w_index];
  assign w_line_match = r_valid[w_index] && (r_tag[w_index] == w_tag);

  assign w_fill_index = r_mem_address[IB+1:2];
  assign w_fill_tag   = r_mem_address[WORD_SIZE-1:IB+2];

  assign w_flush_any  = bus.flush || r_flush_pending;

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign w_words[gi] = w_sel_line[gi*WORD_SIZE +: WORD_SIZE];
  end

  // Next-state and decode. Hits are only ever reported from IDLE.
  always_comb begin
    w_state_next = r_state;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_readM) begin
          if (w_line_match) begin
            w_hit = 1'b1;
          end else begin
            w_miss       = 1'b1;
            w_state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_ready) begin
          w_fill       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, valid bits, flush bookkeeping, fill address and counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state         <= ST_IDLE;
      r_valid         <= '0;
      r_flush_pending <= 1'b0;
      r_mem_address   <= '0;
      r_num_hit       <= '0;
      r_num_miss      <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_hit) begin
        r_num_hit <= r_num_hit + ONE;
      end

      if (w_miss) begin
        r_num_miss    <= r_num_miss + ONE;
        r_mem_address <= {bus.i_address[WORD_SIZE-1:2], 2'b00};
      end

      if (r_state == ST_IDLE) begin
        // The lookup this cycle already used the pre-flush valid bits.
        if (w_flush_any) begin
          r_valid         <= '0;
          r_flush_pending <= 1'b0;
        end
      end else begin
        if (w_fill) begin
          // A flush seen at any point of the fill (including its last
          // cycle) leaves the new line invalid along with all others.
          if (w_flush_any) begin
            r_valid         <= '0;
            r_flush_pending <= 1'b0;
          end else begin
            r_valid[w_fill_index] <= 1'b1;
          end
        end else if (bus.flush) begin
          r_flush_pending <= 1'b1;
        end
      end
    end
  end

  // Line data and tags carry no reset; their valid bits guard them.
  // A reset edge abandons an in-flight fill without writing it.
  always_ff @(posedge Clk) begin
    if (w_fill && !Reset) begin
      r_line[w_fill_index] <= bus.mem_data;
      r_tag[w_fill_index]  <= w_fill_tag;
    end
  end

  assign bus.i_hit       = w_hit;
  assign bus.i_data      = w_hit ? w_words[w_offset] : '0;
  assign bus.i_stall     = bus.i_readM && !w_hit;
  assign bus.mem_readM   = (r_state == ST_REQ);
  assign bus.mem_address = r_mem_address;
  assign bus.num_hit     = r_num_hit;
  assign bus.num_miss    = r_num_miss;

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;
  localparam int LINES = 8;

  logic clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;

  always #5 clk = ~clk;

  instr_cache_if #(.WORD_SIZE(16)) bus ();

  instr_cache #(.LINES(LINES), .WORD_SIZE(16)) dut (
    .Clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Backing memory contents: word at address a is (a - 15).
  function automatic logic [63:0] line_of(input logic [15:0] a);
    logic [63:0] l;
    logic [15:0] base;
    logic [15:0] w;
    base = {a[15:2], 2'b00};
    for (int k = 0; k < 4; k++) begin
      w = base + 16'(k) - 16'd15;
      l[16*k +: 16] = w;
    end
    return l;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 0;
  bit          m_req, m_pend;
  bit          m_valid [LINES];
  logic [13:0] m_laddr [LINES];
  logic [15:0] m_words [LINES][4];
  logic [15:0] m_maddr, m_nh, m_nm;

  function automatic int idx_of(input logic [15:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic bit model_hit(input bit rd, input logic [15:0] a);
    int i;
    i = idx_of(a);
    return rd && !m_req && m_valid[i] && (m_laddr[i] == a[15:2]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (Reset === 1'b1) begin
        m_known = 1;
        m_req   = 0;
        m_pend  = 0;
        m_maddr = 0;
        m_nh    = 0;
        m_nm    = 0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
      end else if (m_known) begin
        if (!m_req) begin
          bit h;
          h = model_hit(bus.i_readM, bus.i_address);
          if (bus.i_readM) $display("txn %s addr=%h", h ? "hit " : "miss", bus.i_address);
          if (h) m_nh = m_nh + 16'd1;
          if (bus.i_readM && !h) begin
            m_req   = 1;
            m_maddr = {bus.i_address[15:2], 2'b00};
            m_nm    = m_nm + 16'd1;
          end
          if (bus.flush || m_pend) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 0;
            m_pend = 0;
          end
        end else if (bus.mem_ready) begin
          int li;
          li = idx_of(m_maddr);
          m_laddr[li] = m_maddr[15:2];
          for (int k = 0; k < 4; k++) m_words[li][k] = bus.mem_data[16*k +: 16];
          if (bus.flush || m_pend) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 0;
            m_pend = 0;
          end else begin
            m_valid[li] = 1;
          end
          m_req = 0;
        end else if (bus.flush) begin
          m_pend = 1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (m_known) begin
      bit          e_hit;
      logic [15:0] e_data;
      e_hit  = model_hit(bus.i_readM, bus.i_address);
      e_data = e_hit ? m_words[idx_of(bus.i_address)][bus.i_address[1:0]] : 16'h0000;
      chk("cyc_hit",   bus.i_hit, e_hit);
      chk("cyc_data",  bus.i_data, e_data);
      chk("cyc_stall", bus.i_stall, bus.i_readM && !e_hit);
      chk("cyc_mrd",   bus.mem_readM, m_req);
      chk("cyc_maddr", bus.mem_address, m_maddr);
      chk("cyc_nhit",  bus.num_hit, m_nh);
      chk("cyc_nmiss", bus.num_miss, m_nm);
    end
  end

  // Memory responder: answers after 'lat' REQ cycles, noise outside REQ
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_readM === 1'b1) begin
        if (cnt >= lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_data  = line_of(bus.mem_address);
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_data  = {$urandom, $urandom};
        end
        cnt++;
      end else begin
        cnt = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_data  = {$urandom, $urandom};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hit(input string nm, input int budget);
    int n;
    n = 0;
    while (bus.i_hit !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, bus.i_hit, 1'b1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (bus.mem_readM !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, bus.mem_readM, 1'b0);
  endtask

  initial begin
    int n;
    logic [15:0] nm0;
    Reset         = 1'b1;
    bus.i_readM   = 1'b0;
    bus.i_address = '0;
    bus.flush     = 1'b0;
    tick();
    tick();
    chk("rst_nhit", bus.num_hit, 16'd0);
    chk("rst_nmiss", bus.num_miss, 16'd0);
    chk("rst_mrd", bus.mem_readM, 1'b0);
    chk("rst_maddr", bus.mem_address, 16'd0);
    chk("pin_line", line_of(16'h0012), 64'h0004_0003_0002_0001);
    Reset = 1'b0;

    // Cold miss then hit
    lat = 0;
    bus.i_readM = 1'b1; bus.i_address = 16'h0012; #1;
    chk("cold_stall0", bus.i_stall, 1'b1);
    chk("cold_hit0", bus.i_hit, 1'b0);
    tick();
    chk("cold_stall1", bus.i_stall, 1'b1);
    chk("cold_mrd", bus.mem_readM, 1'b1);
    chk("cold_maddr", bus.mem_address, 16'h0010);
    tick();
    chk("cold_hit", bus.i_hit, 1'b1);
    chk("cold_data", bus.i_data, 16'h0003);
    chk("cold_nmiss", bus.num_miss, 16'd1);
    tick();
    chk("cold_nhit", bus.num_hit, 16'd1);
    chk("pin_model_nh", m_nh, 16'd1);

    // Spatial hits
    bus.i_address = 16'h0010; #1;
    chk("sp0_hit", bus.i_hit, 1'b1); chk("sp0_data", bus.i_data, 16'h0001);
    tick(); bus.i_address = 16'h0011; #1;
    chk("sp1_hit", bus.i_hit, 1'b1); chk("sp1_data", bus.i_data, 16'h0002);
    tick(); bus.i_address = 16'h0013; #1;
    chk("sp2_hit", bus.i_hit, 1'b1); chk("sp2_data", bus.i_data, 16'h0004);
    tick(); bus.i_readM = 1'b0; #1;
    chk("sp_nhit", bus.num_hit, 16'd4);
    chk("sp_mrd", bus.mem_readM, 1'b0);

    // Conflict eviction: 0x30 and 0x10 share index 4
    bus.i_readM = 1'b1; bus.i_address = 16'h0030; #1;
    chk("cf0_hit", bus.i_hit, 1'b0);
    tick();
    wait_hit("cf0_fill", 20);
    chk("cf0_data", bus.i_data, 16'h0021);
    tick(); bus.i_address = 16'h0010; #1;
    chk("cf1_hit", bus.i_hit, 1'b0);
    tick();
    chk("cf1_maddr", bus.mem_address, 16'h0010);
    wait_hit("cf1_fill", 20);
    chk("cf_nmiss", bus.num_miss, 16'd3);
    chk("pin_model_nm", m_nm, 16'd3);

    // Slow memory with address wandering during REQ
    tick(); lat = 5; nm0 = bus.num_miss;
    bus.i_address = 16'h0044; #1;
    chk("slow_hit0", bus.i_hit, 1'b0);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.mem_readM !== 1'b1) break;
      n++;
      chk("slow_maddr", bus.mem_address, 16'h0044);
      bus.i_address = 16'($urandom);
    end
    chk("slow_reqcyc", n, 6);
    bus.i_address = 16'h0046; #1;
    chk("slow_hit", bus.i_hit, 1'b1);
    chk("slow_data", bus.i_data, 16'h0037);
    chk("slow_onemiss", bus.num_miss, nm0 + 16'd1);

    // Flush during the 2nd REQ cycle
    tick(); lat = 3;
    bus.i_address = 16'h0080; #1;
    tick();
    tick(); bus.flush = 1'b1;
    tick(); bus.flush = 1'b0;
    wait_idle("fl_done", 20);
    #1;
    chk("fl_miss80", bus.i_hit, 1'b0);
    tick();
    wait_hit("fl_refill", 20);
    tick(); bus.i_address = 16'h0044; #1;
    chk("fl_miss44", bus.i_hit, 1'b0);
    tick();
    wait_hit("fl_refill44", 20);

    // Reset mid-REQ
    tick(); lat = 4;
    bus.i_address = 16'h0020; #1;
    tick();
    tick(); Reset = 1'b1; bus.i_readM = 1'b0;
    tick();
    chk("rr_mrd", bus.mem_readM, 1'b0);
    chk("rr_nhit", bus.num_hit, 16'd0);
    chk("rr_nmiss", bus.num_miss, 16'd0);
    Reset = 1'b0; bus.i_readM = 1'b1; bus.i_address = 16'h0020; #1;
    chk("rr_miss", bus.i_hit, 1'b0);
    chk("rr_stall", bus.i_stall, 1'b1);
    tick();
    wait_hit("rr_refill", 20);

    // Randomized traffic checked by the per-cycle model compare
    for (int c = 0; c < 3000; c++) begin
      tick();
      Reset       = ($urandom_range(0, 499) == 0);
      bus.i_readM = ($urandom_range(0, 3) != 0);
      bus.i_address = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      bus.flush   = ($urandom_range(0, 39) == 0);
      lat         = $urandom_range(0, 3);
    end
    tick();
    Reset = 1'b0; bus.i_readM = 1'b0; bus.flush = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
